// File: rtl/riscv_pkg.sv
// Shared types and constants for the LSU MMIO path.
package riscv_pkg;

  // MMIO transaction sequencer states
  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitRsp,
    StDone
  } mmio_state_e;

  // Access classification of the instruction currently in the LSU
  typedef enum logic [1:0] {
    AccNone,
    AccLoad,
    AccStore,
    AccAtomic
  } acc_type_e;

  localparam int unsigned DefNumRegions = 4;

  localparam logic [63:0] UartBase  = 64'h0000_0000_1000_0000;
  localparam logic [63:0] UartMask  = 64'h0000_0000_0000_0FFF;
  localparam logic [63:0] ClintBase = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ClintMask = 64'h0000_0000_0000_FFFF;

  // Region 0 occupies the least significant slice
  localparam logic [DefNumRegions*64-1:0] DefRegionBase = {64'h0, 64'h0, ClintBase, UartBase};
  localparam logic [DefNumRegions*64-1:0] DefRegionMask = {64'h0, 64'h0, ClintMask, UartMask};

  // Atomics take precedence so they never reach the MMIO sequencer
  function automatic acc_type_e acc_type(input logic rden, input logic wren, input logic atomic);
    if (atomic) return AccAtomic;
    if (wren) return AccStore;
    if (rden) return AccLoad;
    return AccNone;
  endfunction

endpackage

// File: rtl/riscv_mmio_decoder.sv
// Combinational address decoder for the memory-mapped windows.
module riscv_mmio_decoder
  import riscv_pkg::*;
#(
  parameter int unsigned                    XLEN        = 64,
  parameter int unsigned                    NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS*XLEN-1:0]    REGION_BASE = '0,
  parameter logic [NUM_REGIONS*XLEN-1:0]    REGION_MASK = '0
) (
  input  logic [XLEN-1:0]        addr_i,
  output logic                   hit_o,
  output logic [NUM_REGIONS-1:0] sel_o,
  output logic [XLEN-1:0]        offset_o
);

  // Lowest-numbered matching region wins; a zero mask disables a region
  always_comb begin
    logic found;
    found    = 1'b0;
    hit_o    = 1'b0;
    sel_o    = '0;
    offset_o = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (!found && (REGION_MASK[k*XLEN +: XLEN] != '0) &&
          ((addr_i & ~REGION_MASK[k*XLEN +: XLEN]) == REGION_BASE[k*XLEN +: XLEN])) begin
        found    = 1'b1;
        hit_o    = 1'b1;
        sel_o[k] = 1'b1;
        offset_o = addr_i & REGION_MASK[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/riscv_lsu_mmio.sv
// Load/store unit front end: dcache forwarding, LR/SC reservation and an
// MMIO request sequencer for accesses that land in a mapped window.
module riscv_lsu_mmio
  import riscv_pkg::*;
#(
  parameter int unsigned                 XLEN           = 64,
  parameter int unsigned                 NUM_REGIONS    = 4,
  parameter logic [NUM_REGIONS*XLEN-1:0] REGION_BASE    = DefRegionBase,
  parameter logic [NUM_REGIONS*XLEN-1:0] REGION_MASK    = DefRegionMask,
  parameter int unsigned                 RESV_GRAN_LOG2 = 3,
  parameter int unsigned                 RESV_TIMEOUT   = 64
) (
  input  logic                   i_riscv_lsu_clk,
  input  logic                   i_riscv_lsu_rst,
  input  logic                   i_riscv_lsu_globstall,
  input  logic [XLEN-1:0]        i_riscv_lsu_address,
  input  logic [XLEN-1:0]        i_riscv_lsu_alu_result,
  input  logic [XLEN-1:0]        i_riscv_lsu_wdata,
  input  logic [1:0]             i_riscv_lsu_lr,
  input  logic [1:0]             i_riscv_lsu_sc,
  input  logic                   i_riscv_lsu_amo,
  input  logic                   i_riscv_lsu_dcache_wren,
  input  logic                   i_riscv_lsu_dcache_rden,
  input  logic                   i_riscv_lsu_goto_trap,
  input  logic                   i_riscv_lsu_return_trap,
  output logic                   o_riscv_lsu_dcache_wren,
  output logic                   o_riscv_lsu_dcache_rden,
  output logic [XLEN-1:0]        o_riscv_lsu_phy_address,
  output logic [XLEN-1:0]        o_riscv_lsu_sc_rdvalue,
  output logic                   o_riscv_lsu_mmio_valid,
  output logic [NUM_REGIONS-1:0] o_riscv_lsu_mmio_sel,
  output logic                   o_riscv_lsu_mmio_we,
  output logic [XLEN-1:0]        o_riscv_lsu_mmio_offset,
  output logic [XLEN-1:0]        o_riscv_lsu_mmio_wdata,
  input  logic                   i_riscv_lsu_mmio_ready,
  input  logic                   i_riscv_lsu_mmio_rsp_valid,
  input  logic [XLEN-1:0]        i_riscv_lsu_mmio_rdata,
  output logic [XLEN-1:0]        o_riscv_lsu_mmio_rdata,
  output logic                   o_riscv_lsu_mmio_stall
);

  localparam int unsigned    AgeW     = (RESV_TIMEOUT > 0) ? $clog2(RESV_TIMEOUT + 1) : 1;
  localparam logic [AgeW-1:0] AgeMax   = '1;
  localparam logic [AgeW-1:0] AgeLimit = AgeW'(RESV_TIMEOUT);

  logic                   rst;
  logic                   trap, is_lr, is_sc, atomic;
  logic                   hit;
  logic [NUM_REGIONS-1:0] hit_sel;
  logic [XLEN-1:0]        hit_offset;
  acc_type_e              acc;

  assign rst    = i_riscv_lsu_rst;
  assign trap   = i_riscv_lsu_goto_trap | i_riscv_lsu_return_trap;
  assign is_lr  = i_riscv_lsu_lr[1];
  assign is_sc  = i_riscv_lsu_sc[1];
  assign atomic = is_lr | is_sc | i_riscv_lsu_amo;
  assign acc    = acc_type(i_riscv_lsu_dcache_rden, i_riscv_lsu_dcache_wren, atomic);

  riscv_mmio_decoder #(
    .XLEN        (XLEN),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decoder (
    .addr_i   (i_riscv_lsu_alu_result),
    .hit_o    (hit),
    .sel_o    (hit_sel),
    .offset_o (hit_offset)
  );

  // ---------------------------------------------------------------------------
  // LR/SC reservation
  // ---------------------------------------------------------------------------
  logic            resv_valid_q, resv_valid_d;
  logic            resv_dw_q, resv_dw_d;
  logic [XLEN-1:0] resv_gran_q, resv_gran_d;
  logic [AgeW-1:0] resv_age_q, resv_age_d;
  logic [XLEN-1:0] atomic_gran, store_gran;
  logic            expired, resv_live, sc_ok;

  assign atomic_gran = i_riscv_lsu_address >> RESV_GRAN_LOG2;
  assign store_gran  = i_riscv_lsu_alu_result >> RESV_GRAN_LOG2;
  assign expired     = (RESV_TIMEOUT != 0) && (resv_age_q >= AgeLimit);
  assign resv_live   = resv_valid_q && !expired;
  // An SC into an MMIO window cannot write, so it always reports failure
  assign sc_ok       = is_sc && resv_live && (atomic_gran == resv_gran_q) &&
                       (i_riscv_lsu_sc[0] == resv_dw_q) && !trap && !hit;

  // Reservation next state: trap beats LR, LR beats the clearing events
  always_comb begin
    resv_valid_d = resv_valid_q;
    resv_dw_d    = resv_dw_q;
    resv_gran_d  = resv_gran_q;
    resv_age_d   = resv_age_q;
    if (resv_valid_q && !i_riscv_lsu_globstall && (resv_age_q != AgeMax)) begin
      resv_age_d = resv_age_q + 1'b1;
    end
    if (trap) begin
      resv_valid_d = 1'b0;
    end else if (is_lr && !i_riscv_lsu_globstall && !hit) begin
      resv_valid_d = 1'b1;
      resv_dw_d    = i_riscv_lsu_lr[0];
      resv_gran_d  = atomic_gran;
      resv_age_d   = '0;
    end else if (is_sc || ((acc == AccStore) && (store_gran == resv_gran_q)) || expired) begin
      resv_valid_d = 1'b0;
    end
  end

  // Reservation registers
  always_ff @(posedge i_riscv_lsu_clk) begin
    if (rst) begin
      resv_valid_q <= 1'b0;
      resv_dw_q    <= 1'b0;
      resv_gran_q  <= '0;
      resv_age_q   <= '0;
    end else begin
      resv_valid_q <= resv_valid_d;
      resv_dw_q    <= resv_dw_d;
      resv_gran_q  <= resv_gran_d;
      resv_age_q   <= resv_age_d;
    end
  end

  // ---------------------------------------------------------------------------
  // MMIO sequencer
  // ---------------------------------------------------------------------------
  mmio_state_e            state_q, state_d;
  logic [NUM_REGIONS-1:0] req_sel_q;
  logic                   req_we_q;
  logic [XLEN-1:0]        req_off_q, req_wdata_q, rdata_q;
  logic                   start, latch, capture, stall;

  assign start = hit && ((acc == AccLoad) || (acc == AccStore)) && !trap;

  // Next state and stall request; DONE waits for the pipeline to move on
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    latch   = 1'b0;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          stall   = 1'b1;
          latch   = 1'b1;
        end
      end
      StReq: begin
        stall = 1'b1;
        if (i_riscv_lsu_mmio_ready) state_d = req_we_q ? StDone : StWaitRsp;
      end
      StWaitRsp: begin
        stall = 1'b1;
        if (i_riscv_lsu_mmio_rsp_valid) begin
          state_d = StDone;
          capture = 1'b1;
        end
      end
      StDone: begin
        if (!i_riscv_lsu_globstall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register plus request/response holding registers
  always_ff @(posedge i_riscv_lsu_clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_sel_q   <= '0;
      req_we_q    <= 1'b0;
      req_off_q   <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        req_sel_q   <= hit_sel;
        req_we_q    <= (acc == AccStore);
        req_off_q   <= hit_offset;
        req_wdata_q <= i_riscv_lsu_wdata;
      end
      if (capture) rdata_q <= i_riscv_lsu_mmio_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, forced to zero while reset is asserted
  // ---------------------------------------------------------------------------
  logic req_active;
  assign req_active = (state_q == StReq) && !rst;

  assign o_riscv_lsu_mmio_valid  = req_active;
  assign o_riscv_lsu_mmio_sel    = req_active ? req_sel_q : '0;
  assign o_riscv_lsu_mmio_we     = req_active && req_we_q;
  assign o_riscv_lsu_mmio_offset = req_active ? req_off_q : '0;
  assign o_riscv_lsu_mmio_wdata  = req_active ? req_wdata_q : '0;
  assign o_riscv_lsu_mmio_rdata  = rst ? '0 : rdata_q;
  assign o_riscv_lsu_mmio_stall  = stall && !rst;

  assign o_riscv_lsu_dcache_rden = !rst && !hit && !trap && i_riscv_lsu_dcache_rden;
  assign o_riscv_lsu_dcache_wren = !rst && !hit && !trap &&
                                   (is_sc ? sc_ok : i_riscv_lsu_dcache_wren);
  assign o_riscv_lsu_phy_address = rst ? '0 :
                                   (atomic ? i_riscv_lsu_address : i_riscv_lsu_alu_result);
  assign o_riscv_lsu_sc_rdvalue  = {{(XLEN-1){1'b0}}, (!rst && is_sc && !sc_ok)};

endmodule

// File: tb/tb_riscv_lsu_mmio.sv
// Directed and randomized checks for riscv_lsu_mmio with default parameters.
module tb_riscv_lsu_mmio;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NR   = 4;
  localparam int unsigned TMO  = 64;

  logic            clk = 1'b0;
  logic            rst, globstall, amo, wren, rden, goto_trap, ret_trap;
  logic [XLEN-1:0] address, alu_result, wdata;
  logic [1:0]      lr, sc;
  logic            ready, rsp_valid;
  logic [XLEN-1:0] rdata_in;

  logic            d_wren, d_rden, m_valid, m_we, m_stall;
  logic [XLEN-1:0] phy, sc_rd, m_off, m_wdata, m_rdata;
  logic [NR-1:0]   m_sel;

  int unsigned checks = 0;
  int unsigned errors = 0;

  riscv_lsu_mmio dut (
    .i_riscv_lsu_clk            (clk),
    .i_riscv_lsu_rst            (rst),
    .i_riscv_lsu_globstall      (globstall),
    .i_riscv_lsu_address        (address),
    .i_riscv_lsu_alu_result     (alu_result),
    .i_riscv_lsu_wdata          (wdata),
    .i_riscv_lsu_lr             (lr),
    .i_riscv_lsu_sc             (sc),
    .i_riscv_lsu_amo            (amo),
    .i_riscv_lsu_dcache_wren    (wren),
    .i_riscv_lsu_dcache_rden    (rden),
    .i_riscv_lsu_goto_trap      (goto_trap),
    .i_riscv_lsu_return_trap    (ret_trap),
    .o_riscv_lsu_dcache_wren    (d_wren),
    .o_riscv_lsu_dcache_rden    (d_rden),
    .o_riscv_lsu_phy_address    (phy),
    .o_riscv_lsu_sc_rdvalue     (sc_rd),
    .o_riscv_lsu_mmio_valid     (m_valid),
    .o_riscv_lsu_mmio_sel       (m_sel),
    .o_riscv_lsu_mmio_we        (m_we),
    .o_riscv_lsu_mmio_offset    (m_off),
    .o_riscv_lsu_mmio_wdata     (m_wdata),
    .i_riscv_lsu_mmio_ready     (ready),
    .i_riscv_lsu_mmio_rsp_valid (rsp_valid),
    .i_riscv_lsu_mmio_rdata     (rdata_in),
    .o_riscv_lsu_mmio_rdata     (m_rdata),
    .o_riscv_lsu_mmio_stall     (m_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later
  task automatic next();
    @(negedge clk);
  endtask

  task automatic idle();
    globstall = 1'b0; amo = 1'b0; wren = 1'b0; rden = 1'b0;
    goto_trap = 1'b0; ret_trap = 1'b0; lr = 2'b00; sc = 2'b00;
    address = '0; alu_result = 64'h4000_0000; wdata = '0;
    ready = 1'b0; rsp_valid = 1'b0; rdata_in = '0;
  endtask

  task automatic do_lr(input logic [63:0] a, input logic dw);
    next(); idle(); lr = {1'b1, dw}; rden = 1'b1; address = a;
  endtask

  task automatic do_sc(input logic [63:0] a, input logic dw, input logic exp_ok,
                       input string tag);
    next(); idle(); sc = {1'b1, dw}; address = a; wdata = 64'h55;
    #1;
    check({tag, "_rd"}, sc_rd, exp_ok ? 64'd0 : 64'd1);
    check({tag, "_wren"}, {63'd0, d_wren}, {63'd0, exp_ok});
  endtask

  task automatic lr_gap_sc(input int gap, input logic exp_ok, input string tag);
    do_lr(64'h8000_0100, 1'b1);
    for (int i = 0; i < gap; i++) begin next(); idle(); end
    do_sc(64'h8000_0100, 1'b1, exp_ok, tag);
  endtask

  // Counts stall cycles of an MMIO access whose inputs are already applied
  task automatic count_stalls(output int n);
    bit done;
    n = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (m_stall) begin n++; next(); end else done = 1;
    end
  endtask

  // Reference reservation model: granule, width and unstalled age since LR
  bit          r_valid;
  bit          r_dw;
  logic [63:0] r_gran;
  int          r_age;

  initial begin
    int n;
    idle();
    rst = 1'b1;

    // Reset: every output low even with a live-looking access applied
    next();
    address = 64'h8000_0000; alu_result = 64'h1000_0000; rden = 1'b1; sc = 2'b10;
    #1;
    check("rst_valid", {63'd0, m_valid}, 64'd0);
    check("rst_stall", {63'd0, m_stall}, 64'd0);
    check("rst_drden", {63'd0, d_rden}, 64'd0);
    check("rst_dwren", {63'd0, d_wren}, 64'd0);
    check("rst_phy", phy, 64'd0);
    check("rst_scrd", sc_rd, 64'd0);
    check("rst_rdata", m_rdata, 64'd0);
    next(); rst = 1'b0; idle();
    #1;
    check("post_rst_stall", {63'd0, m_stall}, 64'd0);
    check("post_rst_valid", {63'd0, m_valid}, 64'd0);

    // UART store, ready immediately
    next(); alu_result = 64'h1000_0000; wdata = 64'h41; wren = 1'b1; ready = 1'b1;
    #1;
    check("st_idle_stall", {63'd0, m_stall}, 64'd1);
    check("st_dwren", {63'd0, d_wren}, 64'd0);
    check("st_idle_valid", {63'd0, m_valid}, 64'd0);
    next(); #1;
    check("st_valid", {63'd0, m_valid}, 64'd1);
    check("st_sel", {60'd0, m_sel}, 64'h1);
    check("st_we", {63'd0, m_we}, 64'd1);
    check("st_wdata", m_wdata, 64'h41);
    check("st_off", m_off, 64'd0);
    check("st_req_stall", {63'd0, m_stall}, 64'd1);
    next(); #1;
    check("st_done_valid", {63'd0, m_valid}, 64'd0);
    check("st_done_stall", {63'd0, m_stall}, 64'd0);

    // CLINT load: ready after 3 cycles, response 2 cycles after ready
    next(); idle(); alu_result = 64'h0200_BFF8; rden = 1'b1;
    #1;
    check("ld_idle_stall", {63'd0, m_stall}, 64'd1);
    check("ld_drden", {63'd0, d_rden}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      next(); wdata = {$urandom, $urandom};
      #1;
      check("ld_hold_valid", {63'd0, m_valid}, 64'd1);
      check("ld_hold_sel", {60'd0, m_sel}, 64'h2);
      check("ld_hold_we", {63'd0, m_we}, 64'd0);
      check("ld_hold_off", m_off, 64'hBFF8);
      check("ld_hold_stall", {63'd0, m_stall}, 64'd1);
    end
    next(); ready = 1'b1;
    #1;
    check("ld_ready_valid", {63'd0, m_valid}, 64'd1);
    next(); ready = 1'b0;
    #1;
    check("ld_wait_valid", {63'd0, m_valid}, 64'd0);
    check("ld_wait_stall", {63'd0, m_stall}, 64'd1);
    next(); rsp_valid = 1'b1; rdata_in = 64'h1234;
    #1;
    check("ld_rsp_stall", {63'd0, m_stall}, 64'd1);
    next(); rsp_valid = 1'b0; rdata_in = 64'hDEAD; globstall = 1'b1;
    #1;
    check("ld_done_stall", {63'd0, m_stall}, 64'd0);
    check("ld_done_rdata", m_rdata, 64'h1234);
    next(); #1;
    check("ld_done_hold_stall", {63'd0, m_stall}, 64'd0);
    check("ld_done_hold_valid", {63'd0, m_valid}, 64'd0);
    next(); globstall = 1'b0;
    #1;
    check("ld_done_exit_stall", {63'd0, m_stall}, 64'd0);
    next(); idle();
    #1;
    check("ld_after_stall", {63'd0, m_stall}, 64'd0);
    check("ld_after_rdata", m_rdata, 64'h1234);

    // Minimum latencies
    next(); idle(); alu_result = 64'h1000_0010; rden = 1'b1; ready = 1'b1; rsp_valid = 1'b1;
    rdata_in = 64'hCAFE;
    count_stalls(n);
    check("rd_min_stalls", 64'(n), 64'd3);
    check("rd_min_rdata", m_rdata, 64'hCAFE);
    next(); idle(); alu_result = 64'h0200_0040; wren = 1'b1; ready = 1'b1;
    count_stalls(n);
    check("wr_min_stalls", 64'(n), 64'd2);

    // Disabled region, atomic to a window, trapped window access
    next(); idle(); alu_result = 64'h0; rden = 1'b1;
    #1;
    check("nohit_drden", {63'd0, d_rden}, 64'd1);
    check("nohit_stall", {63'd0, m_stall}, 64'd0);
    next(); idle(); amo = 1'b1; wren = 1'b1; rden = 1'b1;
    address = 64'h1000_0000; alu_result = 64'h1000_0000;
    #1;
    check("amo_hit_stall", {63'd0, m_stall}, 64'd0);
    check("amo_hit_dwren", {63'd0, d_wren}, 64'd0);
    next(); idle(); alu_result = 64'h1000_0008; wren = 1'b1; goto_trap = 1'b1;
    #1;
    check("trap_hit_stall", {63'd0, m_stall}, 64'd0);
    next(); idle();
    #1;
    check("trap_hit_valid", {63'd0, m_valid}, 64'd0);

    // LR.D / SC.D in the same granule, then a repeated SC
    do_lr(64'h8000_0000, 1'b1);
    #1;
    check("lr_phy", phy, 64'h8000_0000);
    check("lr_drden", {63'd0, d_rden}, 64'd1);
    do_sc(64'h8000_0004, 1'b1, 1'b1, "sc_ok");
    do_sc(64'h8000_0004, 1'b1, 1'b0, "sc_repeat");
    // Width mismatch, different granule, intervening store
    do_lr(64'h8000_0000, 1'b0);
    do_sc(64'h8000_0000, 1'b1, 1'b0, "sc_width");
    do_lr(64'h8000_0000, 1'b1);
    do_sc(64'h8000_0008, 1'b1, 1'b0, "sc_gran");
    do_lr(64'h8000_0020, 1'b1);
    next(); idle(); wren = 1'b1; alu_result = 64'h8000_0024;
    do_sc(64'h8000_0020, 1'b1, 1'b0, "sc_store");

    // Timeout boundary
    lr_gap_sc(TMO - 1, 1'b1, "sc_age63");
    lr_gap_sc(TMO, 1'b0, "sc_age64");

    // Traps
    do_lr(64'h8000_0000, 1'b1); goto_trap = 1'b1;
    do_sc(64'h8000_0000, 1'b1, 1'b0, "sc_lr_trap");
    do_lr(64'h8000_0000, 1'b1);
    next(); idle(); ret_trap = 1'b1;
    do_sc(64'h8000_0000, 1'b1, 1'b0, "sc_ret_trap");
    do_lr(64'h8000_0000, 1'b1); globstall = 1'b1;
    do_sc(64'h8000_0000, 1'b1, 1'b0, "sc_lr_stalled");

    // Reset while waiting for a response
    next(); idle(); alu_result = 64'h1000_0020; rden = 1'b1; ready = 1'b1;
    next(); #1;
    check("rw_req_valid", {63'd0, m_valid}, 64'd1);
    next(); ready = 1'b0;
    #1;
    check("rw_wait_stall", {63'd0, m_stall}, 64'd1);
    next(); rst = 1'b1;
    next(); rst = 1'b0; idle();
    #1;
    check("rw_valid", {63'd0, m_valid}, 64'd0);
    check("rw_stall", {63'd0, m_stall}, 64'd0);
    check("rw_rdata", m_rdata, 64'd0);
    // Reset while a request is held without ready
    next(); idle(); alu_result = 64'h0200_0010; wren = 1'b1; wdata = 64'h77;
    next(); #1;
    check("rq_valid", {63'd0, m_valid}, 64'd1);
    next(); rst = 1'b1;
    next(); rst = 1'b0; idle();
    #1;
    check("rq_valid_after", {63'd0, m_valid}, 64'd0);
    check("rq_stall_after", {63'd0, m_stall}, 64'd0);

    // Randomized reservation traffic against the reference model
    r_valid = 0; r_dw = 0; r_gran = '0; r_age = 0;
    for (int c = 0; c < 400; c++) begin
      int          op;
      logic [63:0] a;
      bit          dw, st, tr, is_lr, is_sc, is_st, is_ld, ok;
      op = int'($urandom_range(0, 5));
      a  = 64'h8000_0000 + 64'($urandom_range(0, 3) * 8) + 64'($urandom_range(0, 7));
      dw = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0);
      tr = ($urandom_range(0, 15) == 0);
      is_lr = (op == 0); is_sc = (op == 1 || op == 2); is_st = (op == 3); is_ld = (op == 4);
      next(); idle();
      globstall = st;
      if ($urandom_range(0, 1) == 1) goto_trap = tr; else ret_trap = tr;
      if (is_lr) begin lr = {1'b1, dw}; rden = 1'b1; address = a; end
      if (is_sc) begin sc = {1'b1, dw}; address = a; end
      if (is_st) begin wren = 1'b1; alu_result = a; end
      if (is_ld) begin rden = 1'b1; alu_result = a; end
      #1;
      ok = is_sc && r_valid && (r_age < TMO) && ((a >> 3) == r_gran) && (dw == r_dw) && !tr;
      if (is_sc) begin
        check("rnd_sc_rd", sc_rd, ok ? 64'd0 : 64'd1);
        check("rnd_sc_wren", {63'd0, d_wren}, {63'd0, ok});
      end else begin
        check("rnd_wren", {63'd0, d_wren}, {63'd0, is_st && !tr});
        check("rnd_rden", {63'd0, d_rden}, {63'd0, (is_lr || is_ld) && !tr});
      end
      check("rnd_stall", {63'd0, m_stall}, 64'd0);
      if (tr) r_valid = 0;
      else if (is_lr && !st) begin r_valid = 1; r_gran = a >> 3; r_dw = dw; end
      else if (is_sc) r_valid = 0;
      else if (is_st && ((a >> 3) == r_gran)) r_valid = 0;
      if (is_lr && !st && !tr) r_age = 0;
      else if (!st) r_age++;
    end

    next(); idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
